div_rem_unit: RTL and testbench
===============================

DIV_REM_UNIT -- requirements
Module: div_rem_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port iCLK  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port iRST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port iStart  input  1  EX-stage holds a DIV/DIVU/REM/REMU instruction; level, held until oReady.
REQ-005 SHALL have port iOp  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
REQ-006 SHALL have port iDividend  input  WIDTH  rs1 value; sampled at accept.
REQ-007 SHALL have port iDivisor  input  WIDTH  rs2 value; sampled at accept.
REQ-008 SHALL have port iFlush  input  1  ID/EX flush or exception; aborts the operation.
REQ-009 SHALL have port oBusy  output  1  operation in progress; the hazard unit stalls IF..WB while iStart && !oReady.
REQ-010 SHALL have port oReady  output  1  one-cycle pulse; oResult valid.
REQ-011 SHALL have port oResult  output  WIDTH  quotient or remainder per iOp.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE.
REQ-013 Accept SHALL occur in IDLE when iStart=1 and iFlush=0; operands and iOp are registered at that edge.
REQ-014 At accept, signed ops SHALL register magnitudes plus the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
REQ-015 Divisor=0 SHALL take the fast path IDLE->DONE, with quotient all-ones and remainder = dividend (unmodified).
REQ-016 Signed overflow (dividend=-2^(WIDTH-1), divisor=-1) SHALL take the fast path, with quotient = dividend and remainder 0.
REQ-017 Otherwise IDLE->CALC; CALC SHALL run a restoring radix-2 iteration, one quotient bit per cycle, for exactly WIDTH cycles, tracked by a counter of $clog2(WIDTH)+1 bits.
REQ-018 After the last iteration, CALC->FIX; FIX SHALL apply the sign correction (two's complement) and select quotient/remainder, then FIX->DONE.
REQ-019 Latency SHALL be accept edge to oReady: WIDTH+2 cycles normally (34 for WIDTH=32) and 1 cycle on the fast path.
REQ-020 DONE SHALL assert oReady for exactly one cycle, then go to IDLE; a new accept is possible on the next cycle (back-to-back ops).
REQ-021 oResult SHALL hold its value from DONE until the next DONE.
REQ-022 oBusy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-023 iFlush=1 in any state SHALL force IDLE at the next edge, with oReady=0 that cycle and oResult unchanged; iFlush has priority over accept.
REQ-024 iStart deasserting mid-operation without iFlush SHALL be ignored; the operation completes.
REQ-025 iOp/operand changes after accept SHALL have no effect.

Reset
REQ-026 iRST=1 SHALL set state IDLE, counter 0, oBusy 0, oReady 0, oResult 0, and all datapath registers 0.
REQ-027 Reset SHALL take priority over iFlush and iStart; reset mid-CALC aborts with no oReady.

Structure
REQ-028 The iOp encodings and state encodings SHALL live in the shared config/constants include, next to the instruction-type bit indices.
REQ-029 A single sub-module div_rem_step (one combinational restoring step: shift, trial subtract, quotient bit) SHALL be instantiated once.
REQ-030 No other sub-modules; the FSM, counter and sign logic SHALL be in this module.

Verification
REQ-031 DIV 20/-3: accept -> oReady exactly 34 cycles later, oResult=0xFFFFFFFA (-6); REM of the same operands -> 2.
REQ-032 DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 7/0 -> oReady 1 cycle after accept, oResult=7; DIV 7/0 -> 0xFFFFFFFF.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 1-cycle oReady, oResult=0x80000000; REM of the same operands -> 0.
REQ-034 iFlush at cycle 10 of CALC -> IDLE next cycle, no oReady, oBusy=0; a new DIVU 9/3 accepted next cycle -> 3 after 34 cycles.
REQ-035 Two back-to-back ops (REM -7/2 then DIVU 100/10) -> oReady pulses 35 cycles apart, results 0xFFFFFFFF then 10.
REQ-036 iRST asserted mid-CALC -> all outputs 0 next cycle; iStart held high through reset -> accept on the first cycle after iRST drops.

Source files
------------

// File: rtl/div_rem_unit_pkg.sv
// Shared constants for the iterative divide/remainder unit: instruction-type
// bit indices, iOp encodings and FSM state encoding.
package div_rem_unit_pkg;

  // Bit positions within iOp that classify the instruction.
  localparam int unsigned OpUnsignedIdx = 0;
  localparam int unsigned OpRemIdx      = 1;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } divOpE;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } divStateE;

  function automatic logic opIsSigned(input logic [1:0] op);
    return !op[OpUnsignedIdx];
  endfunction

  function automatic logic opIsRem(input logic [1:0] op);
    return op[OpRemIdx];
  endfunction

endpackage

// File: rtl/div_rem_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and emit the resulting quotient bit.
module div_rem_step
  import div_rem_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] iRem,
  input  logic [WIDTH-1:0] iQuo,
  input  logic [WIDTH-1:0] iDivisor,
  output logic [WIDTH-1:0] oRem,
  output logic [WIDTH-1:0] oQuo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {iRem, iQuo[WIDTH-1]};
    trial   = shifted - {1'b0, iDivisor};
    // A borrow out of the top bit means the divisor did not fit: restore.
    if (trial[WIDTH]) begin
      oRem = shifted[WIDTH-1:0];
      oQuo = {iQuo[WIDTH-2:0], 1'b0};
    end else begin
      oRem = trial[WIDTH-1:0];
      oQuo = {iQuo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_rem_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: magnitudes are divided by a restoring
// radix-2 loop, then signs are fixed up; zero divisor and overflow bypass the loop.
module div_rem_unit
  import div_rem_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oReady,
  output logic [WIDTH-1:0] oResult
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

  divStateE         stateQ, stateD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [WIDTH-1:0] remQ, remD;
  logic [WIDTH-1:0] quoQ, quoD;
  logic [WIDTH-1:0] divisorQ, divisorD;
  logic             negQuoQ, negQuoD;
  logic             negRemQ, negRemD;
  logic             isRemQ, isRemD;
  logic [WIDTH-1:0] resultQ, resultD;

  logic [WIDTH-1:0] stepRem, stepQuo;

  div_rem_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .iRem    (remQ),
    .iQuo    (quoQ),
    .iDivisor(divisorQ),
    .oRem    (stepRem),
    .oQuo    (stepQuo)
  );

  logic opSigned, opRem, dvdNeg, dvsNeg, divZero, overflow;

  always_comb begin
    opSigned = opIsSigned(iOp);
    opRem    = opIsRem(iOp);
    dvdNeg   = opSigned && iDividend[WIDTH-1];
    dvsNeg   = opSigned && iDivisor[WIDTH-1];
    divZero  = (iDivisor == '0);
    overflow = opSigned && (iDividend == MinInt) && (iDivisor == '1);
  end

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    remD     = remQ;
    quoD     = quoQ;
    divisorD = divisorQ;
    negQuoD  = negQuoQ;
    negRemD  = negRemQ;
    isRemD   = isRemQ;
    resultD  = resultQ;

    if (iFlush) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (iStart) begin
            isRemD   = opRem;
            negQuoD  = dvdNeg ^ dvsNeg;
            negRemD  = dvdNeg;
            quoD     = dvdNeg ? -iDividend : iDividend;
            divisorD = dvsNeg ? -iDivisor : iDivisor;
            remD     = '0;
            if (divZero) begin
              resultD = opRem ? iDividend : '1;
              stateD  = StDone;
            end else if (overflow) begin
              resultD = opRem ? '0 : iDividend;
              stateD  = StDone;
            end else begin
              cntD   = CntW'(WIDTH);
              stateD = StCalc;
            end
          end
        end
        StCalc: begin
          remD = stepRem;
          quoD = stepQuo;
          cntD = cntQ - CntW'(1);
          if (cntQ == CntW'(1)) begin
            stateD = StFix;
          end
        end
        StFix: begin
          if (isRemQ) begin
            resultD = negRemQ ? -remQ : remQ;
          end else begin
            resultD = negQuoQ ? -quoQ : quoQ;
          end
          stateD = StDone;
        end
        StDone: begin
          stateD = StIdle;
        end
        default: begin
          stateD = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      remQ     <= '0;
      quoQ     <= '0;
      divisorQ <= '0;
      negQuoQ  <= 1'b0;
      negRemQ  <= 1'b0;
      isRemQ   <= 1'b0;
      resultQ  <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      remQ     <= remD;
      quoQ     <= quoD;
      divisorQ <= divisorD;
      negQuoQ  <= negQuoD;
      negRemQ  <= negRemD;
      isRemQ   <= isRemD;
      resultQ  <= resultD;
    end
  end

  // A flush arriving during DONE suppresses the completion pulse.
  always_comb begin
    oBusy   = (stateQ == StCalc) || (stateQ == StFix);
    oReady  = (stateQ == StDone) && !iFlush;
    oResult = resultQ;
  end

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed bench for div_rem_unit: an arithmetic reference model feeds an
// expected-result queue that a per-cycle compare process checks.
module tb_div_rem_unit;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic [1:0]  iOp;
  logic [31:0] iDividend;
  logic [31:0] iDivisor;
  logic        iFlush;
  logic        oBusy;
  logic        oReady;
  logic [31:0] oResult;

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  int readyCyc = 0;
  logic [31:0] expQ[$];
  logic [31:0] holdExp = 32'h0;

  div_rem_unit #(
    .WIDTH(32)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iStart   (iStart),
    .iOp      (iOp),
    .iDividend(iDividend),
    .iDivisor (iDivisor),
    .iFlush   (iFlush),
    .oBusy    (oBusy),
    .oReady   (oReady),
    .oResult  (oResult)
  );

  always #5 iCLK = ~iCLK;

  initial forever begin
    @(posedge iCLK);
    cyc = cyc + 1;
  end

  // RISC-V division semantics, straight from the arithmetic definition.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp = nCmp + 1;
    if (act !== exp) begin
      nFail = nFail + 1;
      $display("FAIL %s: got 0x%h, required 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge iCLK);
    if (iRST) begin
      holdExp = 32'h0;
    end else if (oReady) begin
      if (expQ.size() == 0) begin
        check("unexpected_ready", {31'b0, oReady}, 32'h0);
      end else begin
        holdExp = expQ.pop_front();
        check("ready_result", oResult, holdExp);
      end
    end else begin
      check("hold_result", oResult, holdExp);
    end
  end

  task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit chkLit, input logic [31:0] lit, input bit drop,
                      input string name);
    int lat;
    int expLat;
    bit seen;
    expLat = (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
    expQ.push_back(model(op, a, b));
    iStart = 1'b1;
    iOp = op;
    iDividend = a;
    iDivisor = b;
    @(posedge iCLK);
    #1;
    iOp = ~op;
    iDividend = $urandom;
    iDivisor = $urandom;
    if (drop) iStart = 1'b0;
    check({name, "_busy_after_accept"}, {31'b0, oBusy}, {31'b0, expLat > 1});
    lat = 1;
    seen = 1'b0;
    while (lat <= expLat + 4) begin
      if (oReady) begin
        seen = 1'b1;
        break;
      end
      @(posedge iCLK);
      #1;
      lat = lat + 1;
    end
    if (!seen) begin
      check({name, "_ready_timeout"}, 32'h0, 32'h1);
    end else begin
      readyCyc = cyc;
      check({name, "_latency"}, 32'(lat), 32'(expLat));
      check({name, "_busy_at_ready"}, {31'b0, oBusy}, 32'h0);
      if (chkLit) check({name, "_literal"}, oResult, lit);
    end
    iStart = 1'b0;
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    iRST = 1'b1;
    iStart = 1'b0;
    iOp = 2'b00;
    iDividend = 32'h0;
    iDivisor = 32'h0;
    iFlush = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    check("reset_busy", {31'b0, oBusy}, 32'h0);
    check("reset_ready", {31'b0, oReady}, 32'h0);
    check("reset_result", oResult, 32'h0);
    iRST = 1'b0;
    @(posedge iCLK);
    #1;

    doOp(2'b00, 32'd20, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFA, 0, "div_20_m3");
    doOp(2'b10, 32'd20, 32'hFFFF_FFFD, 1, 32'h0000_0002, 1, "rem_20_m3");
    doOp(2'b01, 32'hFFFF_FFFF, 32'd2, 1, 32'h7FFF_FFFF, 0, "divu_max_2");
    doOp(2'b11, 32'd7, 32'd0, 1, 32'd7, 0, "remu_7_0");
    doOp(2'b00, 32'd7, 32'd0, 1, 32'hFFFF_FFFF, 0, "div_7_0");
    doOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, "div_ovf");
    doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 0, "rem_ovf");
    doOp(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 1, "divu_no_ovf");
    doOp(2'b10, 32'h8000_0000, 32'h0, 1, 32'h8000_0000, 0, "rem_min_0");
    doOp(2'b00, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFF2, 0, "div_m100_7");
    doOp(2'b10, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFFE, 0, "rem_m100_7");
    doOp(2'b11, 32'hFFFF_FFFF, 32'h10, 1, 32'hF, 0, "remu_max_16");

    // Flush while idle must block the accept.
    iStart = 1'b1;
    iOp = 2'b01;
    iDividend = 32'd50;
    iDivisor = 32'd5;
    iFlush = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    iFlush = 1'b0;
    check("idle_flush_busy", {31'b0, oBusy}, 32'h0);
    @(posedge iCLK);
    #1;
    check("idle_flush_busy2", {31'b0, oBusy}, 32'h0);

    // Flush in CALC cycle 10, then a fresh op on the following cycle.
    iStart = 1'b1;
    iOp = 2'b01;
    iDividend = 32'd1000;
    iDivisor = 32'd7;
    @(posedge iCLK);
    #1;
    repeat (9) begin
      @(posedge iCLK);
      #1;
    end
    check("flush_busy_before", {31'b0, oBusy}, 32'h1);
    iFlush = 1'b1;
    @(posedge iCLK);
    #1;
    iFlush = 1'b0;
    iStart = 1'b0;
    check("flush_busy_after", {31'b0, oBusy}, 32'h0);
    check("flush_ready_after", {31'b0, oReady}, 32'h0);
    doOp(2'b01, 32'd9, 32'd3, 1, 32'd3, 0, "divu_9_3_after_flush");

    // Back-to-back completions.
    doOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 0, "rem_m7_2");
    r1 = readyCyc;
    doOp(2'b01, 32'd100, 32'd10, 1, 32'd10, 0, "divu_100_10");
    check("b2b_gap", 32'(readyCyc - r1), 32'd35);

    // Reset mid-CALC with iStart held through it.
    iStart = 1'b1;
    iOp = 2'b00;
    iDividend = 32'hFFFF_FC18;
    iDivisor = 32'd7;
    @(posedge iCLK);
    #1;
    repeat (5) begin
      @(posedge iCLK);
      #1;
    end
    iRST = 1'b1;
    iOp = 2'b01;
    iDividend = 32'd100;
    iDivisor = 32'd10;
    @(posedge iCLK);
    #1;
    check("midrst_busy", {31'b0, oBusy}, 32'h0);
    check("midrst_ready", {31'b0, oReady}, 32'h0);
    check("midrst_result", oResult, 32'h0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    doOp(2'b01, 32'd100, 32'd10, 1, 32'd10, 0, "divu_after_reset");

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(3));
      ra = $urandom;
      rb = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(31));
      doOp(rop, ra, rb, 0, 32'h0, i[0], "random");
    end

    repeat (3) @(posedge iCLK);
    #1;
    check("queue_drained", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
